// File: rtl/mod_ud_counter_if.sv
// Control and status bundle for the up/down counter.
// The master drives the requests and the slave (counter) returns the count and flags.
interface mod_ud_counter_if #(
  parameter int C_WIDTH = 10
);
  logic               clr;
  logic               load;
  logic [C_WIDTH-1:0] load_val;
  logic               en;
  logic               up;
  logic               sat;
  logic               ovf_clr;
  logic [C_WIDTH-1:0] c_out;
  logic               tc;
  logic               ovf;
  logic               zero;

  modport master (
    output clr, load, load_val, en, up, sat, ovf_clr,
    input  c_out, tc, ovf, zero
  );

  modport slave (
    input  clr, load, load_val, en, up, sat, ovf_clr,
    output c_out, tc, ovf, zero
  );
endinterface

// File: rtl/mod_ud_counter.sv
// Up/down counter over 0..C_MAX with wrap/saturate modes, terminal-count pulse and sticky overflow.
// One-cycle latency from request to registered count/flags; always ready, no backpressure.
module mod_ud_counter #(
  parameter int C_WIDTH = 10,
  parameter int C_MAX   = 1023
) (
  input  logic            c_clk,
  input  logic            c_reset_n,
  mod_ud_counter_if.slave cif
);

  localparam logic [C_WIDTH-1:0] MAX_V = C_WIDTH'(C_MAX);
  localparam logic [C_WIDTH-1:0] ONE_V = C_WIDTH'(1);

  logic [C_WIDTH-1:0] cnt_q, cnt_d;
  logic               tc_q, tc_d;
  logic               ovf_q, ovf_d;
  logic               at_max, at_min, bound;

  always_comb begin
    at_max = (cnt_q == MAX_V);
    at_min = (cnt_q == '0);
    bound  = cif.en && (cif.up ? at_max : at_min);
    cnt_d  = cnt_q;
    tc_d   = 1'b0;
    ovf_d  = ovf_q;

    // ovf_clr is applied first so a same-cycle bound event overrides it
    if (cif.ovf_clr) begin
      ovf_d = 1'b0;
    end

    if (cif.clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (cif.load) begin
      cnt_d = (cif.load_val > MAX_V) ? MAX_V : cif.load_val;
    end else if (cif.en) begin
      if (bound) begin
        if (cif.up) begin
          cnt_d = cif.sat ? MAX_V : '0;
        end else begin
          cnt_d = cif.sat ? '0 : MAX_V;
        end
        tc_d  = 1'b1;
        ovf_d = 1'b1;
      end else begin
        cnt_d = cif.up ? (cnt_q + ONE_V) : (cnt_q - ONE_V);
      end
    end
  end

  always_ff @(posedge c_clk or negedge c_reset_n) begin
    if (!c_reset_n) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign cif.c_out = cnt_q;
  assign cif.tc    = tc_q;
  assign cif.ovf   = ovf_q;
  assign cif.zero  = (cnt_q == '0);

endmodule

// File: tb/tb_mod_ud_counter.sv
// Scoreboarded bench for mod_ud_counter (C_WIDTH=4, C_MAX=9): directed scenarios then random traffic.
module tb_mod_ud_counter;

  localparam int W   = 4;
  localparam int MAX = 9;

  typedef struct {
    int cnt;
    bit tc;
    bit ovf;
    bit zero;
  } exp_t;

  logic c_clk;
  logic c_reset_n;

  mod_ud_counter_if #(.C_WIDTH(W)) ifc ();

  mod_ud_counter #(.C_WIDTH(W), .C_MAX(MAX)) dut (
    .c_clk     (c_clk),
    .c_reset_n (c_reset_n),
    .cif       (ifc.slave)
  );

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // reference state
  int m_cnt = 0;
  bit m_tc  = 0;
  bit m_ovf = 0;

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: one expected record per edge following a stimulus step
  initial begin
    exp_t e;
    forever begin
      @(posedge c_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("c_out", int'(ifc.c_out), e.cnt);
        chk("tc",    int'(ifc.tc),    int'(e.tc));
        chk("ovf",   int'(ifc.ovf),   int'(e.ovf));
        chk("zero",  int'(ifc.zero),  int'(e.zero));
      end
    end
  end

  // behavioural model of one edge, then queue the expected outputs
  task automatic step(input bit clr, input bit load, input int lv, input bit en,
                      input bit up, input bit sat, input bit ovf_clr);
    exp_t e;
    bit   hit;
    @(posedge c_clk);
    #2;
    ifc.clr      = clr;
    ifc.load     = load;
    ifc.load_val = W'(lv);
    ifc.en       = en;
    ifc.up       = up;
    ifc.sat      = sat;
    ifc.ovf_clr  = ovf_clr;

    hit  = 0;
    m_tc = 0;
    if (clr) begin
      m_cnt = 0;
      m_ovf = 0;
    end else begin
      if (ovf_clr) m_ovf = 0;
      if (load) begin
        m_cnt = (lv > MAX) ? MAX : lv;
      end else if (en) begin
        hit = up ? (m_cnt == MAX) : (m_cnt == 0);
        if (up) m_cnt = sat ? ((m_cnt + 1 > MAX) ? MAX : m_cnt + 1) : (m_cnt + 1) % (MAX + 1);
        else    m_cnt = sat ? ((m_cnt - 1 < 0) ? 0 : m_cnt - 1) : (m_cnt + MAX) % (MAX + 1);
        if (hit) begin
          m_tc  = 1;
          m_ovf = 1;
        end
      end
    end
    e.cnt  = m_cnt;
    e.tc   = m_tc;
    e.ovf  = m_ovf;
    e.zero = (m_cnt == 0);
    exp_q.push_back(e);
  endtask

  // idle step keeps the model valid over any unmonitored edges that follow
  task automatic drain();
    int budget;
    step(0, 0, 0, 0, 0, 0, 0);
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge c_clk);
      #3;
      budget--;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.clr = 0; ifc.load = 0; ifc.load_val = '0; ifc.en = 0;
    ifc.up = 0; ifc.sat = 0; ifc.ovf_clr = 0;
    c_reset_n = 0;
    #12;
    chk("rst_c_out", int'(ifc.c_out), 0);
    chk("rst_tc",    int'(ifc.tc),    0);
    chk("rst_ovf",   int'(ifc.ovf),   0);
    chk("rst_zero",  int'(ifc.zero),  1);
    @(posedge c_clk);
    #2;
    c_reset_n = 1;

    // wrap up from 0 for 12 edges
    for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 1, 0, 0);
    // saturate down from 2
    step(0, 1, 2, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 1, 0);
    // load clamp, then clr over load
    step(0, 1, 15, 1, 1, 0, 0);
    step(1, 1, 5, 1, 1, 0, 0);
    // wrap down from 0, then bound event alongside ovf_clr
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0, 1);
    step(0, 0, 0, 0, 1, 0, 1);
    // saturate up held at max: tc every cycle
    step(0, 1, 9, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 1, 0);
    // run to 7 then async reset between edges
    step(0, 1, 7, 0, 1, 0, 0);
    drain();
    @(posedge c_clk);
    #3;
    c_reset_n = 0;
    #1;
    chk("arst_c_out", int'(ifc.c_out), 0);
    chk("arst_ovf",   int'(ifc.ovf),   0);
    chk("arst_zero",  int'(ifc.zero),  1);
    m_cnt = 0; m_tc = 0; m_ovf = 0;
    @(posedge c_clk);
    #2;
    c_reset_n = 1;
    step(0, 0, 0, 1, 1, 0, 0);

    for (int i = 0; i < 600; i++) begin
      bit r_clr, r_load, r_en, r_oc;
      r_clr  = ($urandom_range(15) == 0);
      r_load = ($urandom_range(7) == 0);
      r_en   = ($urandom_range(3) != 0);
      r_oc   = !r_load && ($urandom_range(7) == 0);
      step(r_clr, r_load, int'($urandom_range(15)), r_en,
           1'($urandom_range(1)), 1'($urandom_range(1)), r_oc);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_ud_counter.md
MOD_UD_COUNTER -- requirements
Module: mod_ud_counter

Interface
REQ-001 SHALL provide parameter C_WIDTH, default 10, counter width in bits.
REQ-002 SHALL provide parameter C_MAX, default 1023, terminal (maximum) count value.
REQ-003 SHALL support only parameter sets with 1 <= C_MAX <= 2**C_WIDTH-1; other values are unsupported.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 c_clk  input  1  clock; all state changes on its rising edge.
REQ-006 c_reset_n  input  1  asynchronous active-low reset.
REQ-007 clr  input  1  synchronous clear of count and overflow flag.
REQ-008 load  input  1  synchronous load request.
REQ-009 load_val  input  C_WIDTH  value to load.
REQ-010 en  input  1  count enable.
REQ-011 up  input  1  direction: 1 = up, 0 = down.
REQ-012 sat  input  1  mode: 1 = saturate at bounds, 0 = wrap modulo C_MAX+1.
REQ-013 ovf_clr  input  1  synchronous clear of the sticky overflow flag only.
REQ-014 c_out  output  C_WIDTH  current count, registered.
REQ-015 tc  output  1  terminal-count pulse, registered, one cycle wide.
REQ-016 ovf  output  1  sticky flag: a bound has been hit since the last clear.
REQ-017 zero  output  1  combinational: c_out == 0.

Function
REQ-018 Per edge, priority SHALL be: clr > load > en; a lower-priority request in the same cycle is ignored.
REQ-019 clr=1: c_out SHALL become 0; tc SHALL become 0; ovf SHALL become 0.
REQ-020 load=1: c_out SHALL become min(load_val, C_MAX); tc SHALL become 0; ovf is unchanged.
REQ-021 en=1, up=1, c_out < C_MAX: c_out SHALL increment by 1.
REQ-022 en=1, up=0, c_out > 0: c_out SHALL decrement by 1.
REQ-023 en=1, up=1, c_out == C_MAX: wrap mode SHALL set c_out to 0; saturate mode SHALL hold C_MAX.
REQ-024 en=1, up=0, c_out == 0: wrap mode SHALL set c_out to C_MAX; saturate mode SHALL hold 0.
REQ-025 A bound event (REQ-023/REQ-024) SHALL assert tc for exactly the next cycle, in either mode.
REQ-026 Consecutive bound events (saturate, en held) SHALL assert tc on every such cycle.
REQ-027 A bound event SHALL set ovf to 1; ovf SHALL then hold until clr or ovf_clr.
REQ-028 A bound event and ovf_clr in the same cycle SHALL leave ovf=1 (set wins).
REQ-029 Whenever clr, load and en are all 0, c_out SHALL hold and tc SHALL be 0.
REQ-030 Changing up or sat SHALL take effect on the next enabled edge, with no extra latency.
REQ-031 Arithmetic SHALL be C_WIDTH bits wide; c_out SHALL never exceed C_MAX.

Reset
REQ-032 c_reset_n=0 SHALL immediately (asynchronously) force c_out=0, tc=0 and ovf=0; consequently zero=1.
REQ-033 Reset asserted mid-count SHALL abandon the count; counting SHALL resume from 0 on the first enabled edge after reset is released.
REQ-034 Reset release SHALL be synchronous to c_clk at the integration level; no internal synchronizer is provided.

Verification (C_WIDTH=4, C_MAX=9)
REQ-035 Wrap up: sat=0, up=1, en=1 from 0 for 12 edges -> c_out steps 1..9, 0, 1, 2; tc=1 only the cycle c_out=0 appears; ovf=1 thereafter.
REQ-036 Saturate down: load_val=2, then sat=1, up=0, en=1 for 4 edges -> c_out 1, 0, 0, 0; tc=1 on the 3rd and 4th cycles; zero=1 from the 2nd edge.
REQ-037 Load clamp and priority: load_val=15, load=1, en=1 -> c_out=9, tc=0; next edge clr=1, load=1 -> c_out=0, ovf=0.
REQ-038 Wrap down: c_out=0, sat=0, up=0, en=1 -> c_out=9, tc=1 one cycle; ovf_clr asserted together with a further bound event -> ovf stays 1.
REQ-039 Async reset: c_out=7, drive c_reset_n=0 between edges -> c_out=0 and ovf=0 before the next edge; after release, en=1, up=1 -> c_out=1.
